// File: rtl/regbnk_arbiter_pkg.sv
// regbnk_arbiter shared definitions
// bank geometry, op codes and arbiter FSM states
package regbnk_arbiter_pkg;

  localparam int REGBNK_DW = 16;
  localparam int REGBNK_AW = 4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_st_e;

  // index width for n requesters, never zero
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regbnk_arbiter_rr_pick.sv
// regbnk_arbiter round-robin picker
// first set req bit at or after ptr, wrapping
module regbnk_arbiter_rr_pick
  import regbnk_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int pos;

  // scan ptr, ptr+1, ... modulo NREQ; first hit wins
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      if (!any && req[pos]) begin
        any      = 1'b1;
        win[pos] = 1'b1;
        idx      = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/regbnk_arbiter.sv
// regbnk_arbiter: shares the single-port regbnk
// round-robin with bounded lock; tags read data
module regbnk_arbiter
  import regbnk_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int DW       = REGBNK_DW,
  parameter int AW       = REGBNK_AW,
  parameter int MAX_LOCK = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    rw,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdat,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvld,
  output logic [DW-1:0]      rdat,
  output logic               bnk_cs,
  output logic               bnk_rw,
  output logic [AW-1:0]      bnk_addr,
  output logic [DW-1:0]      bnk_datin,
  input  logic [DW-1:0]      bnk_datout
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_st_e         state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   lcnt;
  logic [NREQ-1:0] rd_tag;

  logic [NREQ-1:0] own_oh;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] win;
  logic [IW-1:0]   widx;
  logic            wany;
  logic [IW-1:0]   nxt;
  logic            own_go;

  // while locked only the owner is eligible
  always_comb begin
    own_oh        = '0;
    own_oh[owner] = 1'b1;
    elig          = (state == ST_LOCKED) ? (req & own_oh) : req;
  end

  regbnk_arbiter_rr_pick #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_pick (
    .req(elig),
    .ptr(ptr),
    .win(win),
    .idx(widx),
    .any(wany)
  );

  // pointer moves past the winner
  always_comb begin
    nxt    = (widx == IW'(NREQ - 1)) ? '0 : widx + IW'(1);
    own_go = req[owner] && lock[owner];
  end

  // Mealy grant and bank mux, silenced in reset
  always_comb begin
    gnt       = rst ? '0 : win;
    bnk_cs    = 1'b0;
    bnk_rw    = RW_WRITE;
    bnk_addr  = '0;
    bnk_datin = '0;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (win[i]) begin
          bnk_cs    = 1'b1;
          bnk_rw    = rw[i];
          bnk_addr  = addr[i*AW +: AW];
          bnk_datin = wdat[i*DW +: DW];
        end
      end
    end
  end

  // arbitration FSM with ptr/owner/lcnt state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      owner <= '0;
      lcnt  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (wany) begin
            ptr <= nxt;
            if (lock[widx]) begin
              owner <= widx;
              lcnt  <= CW'(1);
              if (MAX_LOCK > 1) begin
                state <= ST_LOCKED;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (wany) begin
            ptr <= nxt;
          end
          if (!own_go) begin
            state <= ST_IDLE;
          end else begin
            lcnt <= lcnt + CW'(1);
            if (lcnt == CW'(MAX_LOCK - 1)) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // remember who issued a read for next-cycle rvld
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_tag <= '0;
    end else if (wany && bnk_rw == RW_READ) begin
      rd_tag <= win;
    end else begin
      rd_tag <= '0;
    end
  end

  assign rvld = rst ? '0 : rd_tag;
  assign rdat = bnk_datout;

endmodule

// File: tb/tb_regbnk_arbiter.sv
// tb_regbnk_arbiter: scoreboard bench
// behavioural bank plus reference arbiter
module tb_regbnk_arbiter;
  import regbnk_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int MAXL = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    rw;
  logic [NREQ-1:0]    lock;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdat;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvld;
  logic [DW-1:0]      rdat;
  logic               bnk_cs;
  logic               bnk_rw;
  logic [AW-1:0]      bnk_addr;
  logic [DW-1:0]      bnk_datin;
  logic [DW-1:0]      bnk_datout;

  always #5 clk = ~clk;

  regbnk_arbiter #(
    .NREQ(NREQ), .DW(DW), .AW(AW), .MAX_LOCK(MAXL)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .lock(lock),
    .addr(addr), .wdat(wdat), .gnt(gnt), .rvld(rvld), .rdat(rdat),
    .bnk_cs(bnk_cs), .bnk_rw(bnk_rw), .bnk_addr(bnk_addr),
    .bnk_datin(bnk_datin), .bnk_datout(bnk_datout)
  );

  // single-port bank with registered read data
  logic [DW-1:0] bank [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) bank[i] <= '0;
      bnk_datout <= '0;
    end else if (bnk_cs) begin
      if (bnk_rw == RW_READ) bnk_datout <= bank[bnk_addr];
      else bank[bnk_addr] <= bnk_datin;
    end
  end

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          rq[$];
  logic [DW-1:0] m_mem [16];
  int            m_ptr, m_owner, m_cnt;
  bit            m_locked;
  int            cyc = 0;
  int            vectors = 0;
  int            errors = 0;
  logic [NREQ-1:0] last_rvld;
  logic [DW-1:0]   last_rdat;

  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [63:0] act,
                                logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endfunction

  // rules: owner only while locked, else scan from ptr
  function automatic int pick();
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic void update(int w);
    if (m_locked) begin
      if (!req[m_owner] || !lock[m_owner]) m_locked = 0;
      else begin
        m_cnt++;
        if (m_cnt >= MAXL) m_locked = 0;
      end
    end else if (w >= 0 && lock[w]) begin
      m_owner  = w;
      m_cnt    = 1;
      m_locked = (MAXL > 1);
    end
    if (w >= 0) m_ptr = (w + 1) % NREQ;
  endfunction

  // one clock: check at negedge, advance model, return after posedge
  task automatic tick(output logic [NREQ-1:0] g);
    int w;
    logic [AW-1:0] a;
    @(negedge clk);
    g = gnt;
    last_rvld = rvld;
    last_rdat = rdat;
    if (rst) begin
      check("rst_gnt", gnt, 0);
      check("rst_rvld", rvld, 0);
      check("rst_cs", bnk_cs, 0);
      m_locked = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
      foreach (m_mem[i]) m_mem[i] = '0;
      rq.delete();
    end else begin
      w = pick();
      check("gnt", gnt, (w < 0) ? 64'd0 : (64'd1 << w));
      if (w < 0) begin
        check("bnk_idle", {bnk_cs, bnk_rw, bnk_addr, bnk_datin}, 0);
      end else begin
        a = addr[w*AW +: AW];
        check("bnk_op", {bnk_cs, bnk_rw, bnk_addr, bnk_datin},
              {1'b1, rw[w], a, wdat[w*DW +: DW]});
        if (rw[w] == RW_READ) rq.push_back('{cyc + 1, w, m_mem[a]});
        else m_mem[a] = wdat[w*DW +: DW];
      end
      update(w);
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: match every rvld pulse against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (rvld != '0) begin
        if (rq.size() == 0 || rq[0].due != cyc) begin
          vectors++; errors++;
          $display("FAIL rvld_spurious: got %0h expected 0 at cycle %0d",
                   rvld, cyc);
        end else begin
          check("rvld_id", rvld, 64'd1 << rq[0].id);
          check("rdat", rdat, rq[0].data);
          void'(rq.pop_front());
        end
      end else if (rq.size() > 0 && rq[0].due == cyc) begin
        vectors++; errors++;
        $display("FAIL rvld_missing: got 0 expected %0h at cycle %0d",
                 64'd1 << rq[0].id, cyc);
        void'(rq.pop_front());
      end
    end
  end

  task automatic set_op(int i, logic r, logic w, logic l,
                        logic [AW-1:0] a, logic [DW-1:0] d);
    req[i]           = r;
    rw[i]            = w;
    lock[i]          = l;
    addr[i*AW +: AW] = a;
    wdat[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    logic [NREQ-1:0] g;
    rst = 1'b1;
    tick(g);
    rst = 1'b0;
  endtask

  logic [NREQ-1:0] g;
  logic [1:0] s3 [4];
  logic [1:0] s4 [5];
  int n1;

  initial begin
    rst  = 1'b1;
    req  = '0; rw = '0; lock = '0; addr = '0; wdat = '0;
    s3 = '{2'b01, 2'b10, 2'b01, 2'b10};
    s4 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    // reset held two cycles with both requesting
    set_op(0, 1, RW_WRITE, 0, 4'd1, 16'h1111);
    set_op(1, 1, RW_WRITE, 0, 4'd2, 16'h2222);
    tick(g);
    tick(g);
    rst = 1'b0;

    // contention from reset alternates
    for (int k = 0; k < 4; k++) begin
      tick(g);
      check("t3_seq", g, s3[k]);
    end

    // write then read back through requester 0
    do_reset();
    set_op(1, 0, RW_WRITE, 0, 4'd0, 16'h0);
    set_op(0, 1, RW_WRITE, 0, 4'd3, 16'hBEEF);
    tick(g);
    check("t2_wr_gnt", g, 2'b01);
    set_op(0, 1, RW_READ, 0, 4'd3, 16'h0);
    tick(g);
    check("t2_rd_gnt", g, 2'b01);
    req = '0;
    tick(g);
    check("t2_rvld", last_rvld, 2'b01);
    check("t2_rdat", last_rdat, 16'hBEEF);

    // lock bound: four owner grants, then requester 0
    do_reset();
    set_op(0, 1, RW_WRITE, 0, 4'd4, 16'h0404);
    tick(g);
    set_op(0, 1, RW_WRITE, 0, 4'd5, 16'h0505);
    set_op(1, 1, RW_WRITE, 1, 4'd6, 16'h0600);
    n1 = 0;
    for (int k = 0; k < 12; k++) begin
      tick(g);
      if (k < 5) check("t4_seq", g, s4[k]);
      if (g[0]) req[0] = 1'b0;
      if (g[1]) begin
        n1++;
        wdat[DW +: DW] = 16'h0600 + 16'(n1);
        if (n1 == 6) req[1] = 1'b0;
      end
    end
    check("t4_n1", n1, 6);

    // early unlock: owner drops lock on its second grant
    do_reset();
    set_op(0, 1, RW_WRITE, 0, 4'd7, 16'h0707);
    set_op(1, 0, RW_WRITE, 0, 4'd0, 16'h0);
    tick(g);
    set_op(1, 1, RW_WRITE, 1, 4'd8, 16'h0808);
    tick(g);
    check("t5_g1", g, 2'b10);
    set_op(1, 1, RW_WRITE, 0, 4'd9, 16'h0909);
    tick(g);
    check("t5_g2", g, 2'b10);
    req[1] = 1'b0;
    tick(g);
    check("t5_g3", g, 2'b01);
    req = '0;

    // reset in the cycle after a read grant
    do_reset();
    set_op(0, 1, RW_READ, 0, 4'd5, 16'h0);
    set_op(1, 0, RW_READ, 0, 4'd5, 16'h0);
    tick(g);
    check("t6_rd_gnt", g, 2'b01);
    rst = 1'b1;
    req = '0;
    tick(g);
    check("t6_rvld", last_rvld, 2'b00);
    rst = 1'b0;
    req = 2'b11;
    tick(g);
    check("t6_first", g, 2'b01);
    check("t6_no_rvld", last_rvld, 2'b00);
    req = '0;
    tick(g);

    // randomized traffic with locks and occasional resets
    for (int c = 0; c < 3000; c++) begin
      tick(g);
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (g[i] || !req[i]) begin
          set_op(i, $urandom_range(0, 2) != 0, 1'($urandom),
                 lock[i], 4'($urandom_range(0, 7)), 16'($urandom));
        end
        if ($urandom_range(0, 3) == 0) lock[i] = ($urandom_range(0, 1) == 1);
      end
    end
    rst = 1'b0;
    req = '0;
    tick(g);
    tick(g);
    check("drain", rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
